instr_fetch: RTL and testbench

Instruction fetch unit: owns the program counter, issues word reads to instruction memory over a request/acknowledge handshake, and presents each fetched instruction, its PC and its opcode field to the control/decode stage over a valid/ready handshake. It is the producer side of the opcode path. The control unit consumes `opcode` combinationally; this block generates it. It supports in-order sequential fetch and single-cycle PC redirect for branches and jumps.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/instr_fetch_if.sv | 30 +++
 rtl/instr_fetch_pc_reg.sv | 40 ++++
 rtl/instr_fetch.sv | 101 ++++++++++
 tb/tb_instr_fetch.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch slice: FSM states, widths and
// small PC helpers.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int          INSTR_W    = 32;
  localparam int          OPCODE_W   = 6;
  localparam logic [31:0] PC_INCR    = 32'd4;
  localparam int          OPCODE_MSB = 31;
  localparam int          OPCODE_LSB = 26;

  // Force a target address onto a word boundary.
  function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the instruction-memory request/ack bus, the decode valid/ready
// bus and the redirect inputs seen by the fetch unit.
interface instr_fetch_if;
  import mips_pkg::*;

  logic                  imem_req;
  logic [INSTR_W-1:0]    imem_addr;
  logic                  imem_ack;
  logic [INSTR_W-1:0]    imem_rdata;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [INSTR_W-1:0]    instr;
  logic [INSTR_W-1:0]    instr_pc;
  logic [OPCODE_W-1:0]   opcode;
  logic                  redirect;
  logic [INSTR_W-1:0]    redirect_pc;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, opcode,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  // Memory / decode / branch-resolution side.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, opcode,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register: reset value, +4 advance and redirect load, with
// the redirect load taking priority over the advance.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               incr_i,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] load_pc_i,
  output logic [INSTR_W-1:0] pc_o
);

  logic [INSTR_W-1:0] pc_q;
  logic [INSTR_W-1:0] pc_d;

  // Next PC: redirect target first, then sequential advance (wraps at 2^32).
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = align_pc(load_pc_i);
    end else if (incr_i) begin
      pc_d = pc_q + PC_INCR;
    end
  end

  // PC state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests words from instruction memory at the PC,
// holds each fetched word for decode, and handles branch/jump redirects,
// including draining a request that was already in flight.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master fetch_if
);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] pc;
  logic [INSTR_W-1:0] req_addr_q;
  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] instr_pc_q;
  logic               pc_incr;
  logic               capture;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .incr_i    (pc_incr),
    .load_i    (fetch_if.redirect),
    .load_pc_i (fetch_if.redirect_pc),
    .pc_o      (pc)
  );

  // Next state, PC advance and capture strobe; redirect overrides everything.
  always_comb begin
    state_d = state_q;
    pc_incr = 1'b0;
    capture = 1'b0;
    case (state_q)
      FETCH: begin
        if (fetch_if.redirect) begin
          // Same-cycle ack lets us issue the target next cycle; otherwise the
          // in-flight request must finish first.
          state_d = fetch_if.imem_ack ? FETCH : DRAIN;
        end else if (fetch_if.imem_ack) begin
          capture = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (fetch_if.redirect) begin
          state_d = FETCH;
        end else if (fetch_if.instr_ready) begin
          pc_incr = 1'b1;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (fetch_if.imem_ack) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Held instruction and its PC; only updated on a non-discarded ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else if (capture) begin
      instr_q    <= fetch_if.imem_rdata;
      instr_pc_q <= pc;
    end
  end

  // Address of the outstanding request, kept so DRAIN can hold it while the
  // PC already points at the redirect target.
  always_ff @(posedge clk) begin
    if (state_q == FETCH) begin
      req_addr_q <= pc;
    end
  end

  assign fetch_if.imem_req    = !rst && (state_q != VALID);
  assign fetch_if.imem_addr   = (state_q == DRAIN) ? req_addr_q : pc;
  assign fetch_if.instr_valid = (state_q == VALID);
  assign fetch_if.instr       = instr_q;
  assign fetch_if.instr_pc    = instr_pc_q;
  assign fetch_if.opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: memory model with programmable wait states,
// scoreboard of expected instructions, a vector table for the initial fetch
// stream and hand-written sequences for backpressure, redirects, wrap and reset.
module tb_instr_fetch;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_if (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } sb_t;

  vec_t vecs [6];
  sb_t  sb_q [$];
  int   errors   = 0;
  int   checks   = 0;
  int   mem_wait = 0;
  int   mem_cnt  = 0;
  int   discard  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0020;
    return {a[7:2], a[25:0] ^ 26'h155_5555};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: memory responds, scoreboard watches the decode handshake.
  task automatic step();
    sb_t e;
    #1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    if (bus.imem_req === 1'b1 && mem_cnt >= mem_wait) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = mem_word(bus.imem_addr);
      if (discard > 0) begin
        discard--;
      end else begin
        e.pc   = bus.imem_addr;
        e.word = bus.imem_rdata;
        sb_q.push_back(e);
      end
    end
    if (bus.instr_valid === 1'b1 && (bus.redirect || bus.instr_ready)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: instruction at pc %h presented, none expected", bus.instr_pc);
      end else begin
        e = sb_q.pop_front();
        if (!bus.redirect) begin
          chk("sb_pc", bus.instr_pc, e.pc);
          chk("sb_instr", bus.instr, e.word);
          chk("sb_opcode", {26'b0, bus.opcode}, {26'b0, e.word[31:26]});
        end
      end
    end
    if (bus.imem_ack) mem_cnt = 0;
    else if (bus.imem_req === 1'b1) mem_cnt++;
    else mem_cnt = 0;
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h4, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h4};
    vecs[4] = '{1'b1, 1'b1, 32'h8, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h8};

    rst             = 1'b1;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    step();
    step();
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_opcode", {26'b0, bus.opcode}, 32'h0);

    // Sequential fetch from the vector table, zero-wait memory.
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.instr_ready = vecs[i].ready;
      #1;
      chk("seq_req", {31'b0, bus.imem_req}, {31'b0, vecs[i].exp_req});
      if (vecs[i].exp_req) chk("seq_addr", bus.imem_addr, vecs[i].exp_addr);
      chk("seq_valid", {31'b0, bus.instr_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) chk("seq_instr_pc", bus.instr_pc, vecs[i].exp_pc);
      step();
    end

    // Backpressure: five cycles of valid without ready.
    bus.instr_ready = 1'b0;
    chk("bp_addr", bus.imem_addr, 32'hC);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {31'b0, bus.instr_valid}, 32'd1);
      chk("bp_req", {31'b0, bus.imem_req}, 32'd0);
      chk("bp_instr_pc", bus.instr_pc, 32'hC);
      chk("bp_instr", bus.instr, mem_word(32'hC));
      step();
    end
    bus.instr_ready = 1'b1;
    step();
    chk("bp_next_req", {31'b0, bus.imem_req}, 32'd1);
    chk("bp_next_addr", bus.imem_addr, 32'hC + 32'd4);

    // Wait states: ack after three extra cycles.
    mem_wait = 3;
    for (int k = 0; k < 4; k++) begin
      chk("ws_req", {31'b0, bus.imem_req}, 32'd1);
      chk("ws_addr", bus.imem_addr, 32'h10);
      chk("ws_valid", {31'b0, bus.instr_valid}, 32'd0);
      step();
    end
    chk("ws_valid_after_ack", {31'b0, bus.instr_valid}, 32'd1);
    chk("ws_instr_pc", bus.instr_pc, 32'h10);
    step();

    // Reset pulsed in the middle of a wait state.
    step();
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("mid_rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("mid_rst_instr", bus.instr, 32'h0);
    rst      = 1'b0;
    mem_wait = 0;
    #1;
    chk("mid_rst_addr", bus.imem_addr, 32'h0);
    chk("mid_rst_req_after", {31'b0, bus.imem_req}, 32'd1);

    // Redirect in VALID with a simultaneous ready.
    for (int k = 0; k < 5; k++) step();
    chk("rdv_valid", {31'b0, bus.instr_valid}, 32'd1);
    chk("rdv_instr_pc", bus.instr_pc, 32'h8);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    step();
    bus.redirect = 1'b0;
    chk("rdv_valid_dropped", {31'b0, bus.instr_valid}, 32'd0);
    chk("rdv_req", {31'b0, bus.imem_req}, 32'd1);
    chk("rdv_addr", bus.imem_addr, 32'h0000_0100);
    chk("rdv_sb_empty", sb_q.size(), 32'd0);
    step();
    step();

    // Redirect in FETCH with no ack: the old request drains first.
    mem_wait        = 2;
    discard         = 1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0040;
    step();
    bus.redirect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("drain_req", {31'b0, bus.imem_req}, 32'd1);
      chk("drain_addr", bus.imem_addr, 32'h0000_0104);
      chk("drain_valid", {31'b0, bus.instr_valid}, 32'd0);
      step();
    end
    chk("drain_done_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("drain_done_req", {31'b0, bus.imem_req}, 32'd1);
    chk("drain_done_addr", bus.imem_addr, 32'h0000_0040);
    mem_wait = 0;
    step();
    chk("drain_tgt_valid", {31'b0, bus.instr_valid}, 32'd1);
    chk("drain_tgt_pc", bus.instr_pc, 32'h0000_0040);
    step();

    // Redirect in FETCH coinciding with the ack.
    discard         = 1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    step();
    bus.redirect = 1'b0;
    chk("rfa_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rfa_req", {31'b0, bus.imem_req}, 32'd1);
    chk("rfa_addr", bus.imem_addr, 32'h0000_0200);

    // Wrap: unaligned target forced to the last word, then PC wraps to 0.
    discard         = 1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    step();
    bus.redirect = 1'b0;
    chk("wrap_tgt_addr", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_valid", {31'b0, bus.instr_valid}, 32'd1);
    chk("wrap_instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_req", {31'b0, bus.imem_req}, 32'd1);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    step();
    step();
    chk("end_sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
